// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter. One registered one-hot grant per cycle; a
// granted client keeps the grant for up to weight+1 consecutive cycles while
// it keeps requesting, then priority rotates past it. A stall freezes all
// arbitration state.
//
// Handshake: request[i] is a level held by the client until it observes
// grant[i]; grant is a registered qualifier (no ready/back-pressure here).
// While stall=1 the grant may stay on a client whose request has dropped.
module wrr_arbiter #(
    parameter int CLIENTS  = 32,
    parameter int WEIGHT_W = 4
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [CLIENTS-1:0]           request,
    input  logic [CLIENTS*WEIGHT_W-1:0]  weight,
    input  logic                         stall,
    output logic [CLIENTS-1:0]           grant
);

    localparam int PTR_W = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

    // Decision taken at each unstalled edge; kept as a named signal so
    // checkers can bind to it.
    typedef enum logic [1:0] {
        MODE_IDLE   = 2'd0,
        MODE_HOLD   = 2'd1,
        MODE_ROTATE = 2'd2,
        MODE_STALL  = 2'd3
    } mode_e;

    logic [PTR_W-1:0]    pointer;     // index of the last granted client
    logic [WEIGHT_W-1:0] credit;      // extra cycles left in the current burst
    logic [PTR_W-1:0]    pick;
    logic                pick_valid;
    logic                hold;
    mode_e               mode;

    logic [CLIENTS-1:0]  next_grant;
    logic [WEIGHT_W-1:0] next_credit;
    logic [PTR_W-1:0]    next_pointer;

    // The holder is always the client at pointer while grant is non-zero.
    assign hold = (|grant) && request[pointer] && (credit != '0);

    // Circular search starting just after pointer; the old holder comes last.
    always_comb begin
        int idx;
        logic [PTR_W-1:0] idx_p;
        idx        = 0;
        idx_p      = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = 1; k <= CLIENTS; k++) begin
            idx = int'(pointer) + k;
            if (idx >= CLIENTS) idx = idx - CLIENTS;
            idx_p = PTR_W'(idx);
            if (!pick_valid && request[idx_p]) begin
                pick_valid = 1'b1;
                pick       = idx_p;
            end
        end
    end

    // Classify the coming edge.
    always_comb begin
        mode = MODE_IDLE;
        if (stall)           mode = MODE_STALL;
        else if (hold)       mode = MODE_HOLD;
        else if (pick_valid) mode = MODE_ROTATE;
        else                 mode = MODE_IDLE;
    end

    // Next grant/credit/pointer from the decision.
    always_comb begin
        next_grant   = grant;
        next_credit  = credit;
        next_pointer = pointer;
        case (mode)
            MODE_HOLD: begin
                next_credit = credit - WEIGHT_W'(1);
            end
            MODE_ROTATE: begin
                next_grant       = '0;
                next_grant[pick] = 1'b1;
                next_credit      = weight[pick*WEIGHT_W +: WEIGHT_W];
                next_pointer     = pick;
            end
            MODE_IDLE: begin
                next_grant  = '0;
                next_credit = '0;
            end
            default: begin
                next_grant   = grant;
                next_credit  = credit;
                next_pointer = pointer;
            end
        endcase
    end

    // Arbitration state; reset gives client 0 first priority.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            grant   <= '0;
            credit  <= '0;
            pointer <= PTR_W'(CLIENTS - 1);
        end else begin
            grant   <= next_grant;
            credit  <= next_credit;
            pointer <= next_pointer;
        end
    end

endmodule
